// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pipe
// Brief    : Elastic instruction decoder; splits instructions into fields and
//            buffers decoded packets in a DEPTH-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_pipe #(
    parameter int                            INSTR_WIDTH   = 16,
    parameter int                            OPCODE_WIDTH  = 4,
    parameter int                            REG_SEL_WIDTH = 3,
    parameter int                            IMM_WIDTH     = 8,
    parameter int                            DATA_WIDTH    = 16,
    parameter bit                            SIGN_EXT      = 1'b0,
    parameter logic [OPCODE_WIDTH-1:0]       WRITE_OPCODE  = {OPCODE_WIDTH{1'b1}},
    parameter logic [2**OPCODE_WIDTH-1:0]    ILLEGAL_MASK  = '0,
    parameter int                            DEPTH         = 2,
    parameter int                            COUNT_WIDTH   = 16
) (
    input  logic                      I_clk,
    input  logic                      I_reset,
    input  logic                      I_enable,
    input  logic                      I_flush,
    input  logic [INSTR_WIDTH-1:0]    I_instruction,
    input  logic                      I_valid,
    output logic                      O_ready,
    output logic [OPCODE_WIDTH-1:0]   O_opcode,
    output logic [REG_SEL_WIDTH-1:0]  O_rD_select,
    output logic [REG_SEL_WIDTH-1:0]  O_rA_select,
    output logic [REG_SEL_WIDTH-1:0]  O_rB_select,
    output logic                      O_mode,
    output logic [DATA_WIDTH-1:0]     O_immediate,
    output logic                      O_illegal,
    output logic                      O_valid,
    input  logic                      I_ready,
    output logic [COUNT_WIDTH-1:0]    O_decoded_count
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int PKT_W     = OPCODE_WIDTH + 3*REG_SEL_WIDTH + 1 + DATA_WIDTH + 1;
    localparam int c_RD_LSB  = INSTR_WIDTH - OPCODE_WIDTH - REG_SEL_WIDTH;
    localparam int c_MODE_B  = c_RD_LSB - 1;
    localparam int c_RA_LSB  = c_MODE_B - REG_SEL_WIDTH;
    localparam int c_RB_LSB  = c_RA_LSB - REG_SEL_WIDTH;
    localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

    logic [OPCODE_WIDTH-1:0]  w_opcode;
    logic [REG_SEL_WIDTH-1:0] w_rd;
    logic [REG_SEL_WIDTH-1:0] w_ra;
    logic [REG_SEL_WIDTH-1:0] w_rb;
    logic                     w_mode;
    logic [IMM_WIDTH-1:0]     w_imm_raw;
    logic [IMM_WIDTH-1:0]     w_wr_imm_raw;
    logic [DATA_WIDTH-1:0]    w_imm_norm;
    logic [DATA_WIDTH-1:0]    w_imm;
    logic                     w_illegal;
    logic [PKT_W-1:0]         w_pkt;
    logic [PKT_W-1:0]         w_head;
    logic                     w_push;
    logic                     w_pop;

    logic [PKT_W-1:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic [COUNT_WIDTH-1:0]   r_decoded_count;

    assign w_opcode  = I_instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign w_rd      = I_instruction[c_RD_LSB +: REG_SEL_WIDTH];
    assign w_mode    = I_instruction[c_MODE_B];
    assign w_ra      = I_instruction[c_RA_LSB +: REG_SEL_WIDTH];
    assign w_rb      = I_instruction[c_RB_LSB +: REG_SEL_WIDTH];
    assign w_imm_raw = I_instruction[IMM_WIDTH-1:0];
    assign w_illegal = ILLEGAL_MASK[w_opcode];

    // WRITE format rebuilds the immediate from rD and the low instruction bits,
    // left-aligned in the raw immediate and always zero-extended.
    always_comb begin
        w_wr_imm_raw = '0;
        w_wr_imm_raw[IMM_WIDTH-1 -: 2*REG_SEL_WIDTH] = {w_rd, I_instruction[REG_SEL_WIDTH-1:0]};
        if (SIGN_EXT)
            w_imm_norm = DATA_WIDTH'($signed(w_imm_raw));
        else
            w_imm_norm = DATA_WIDTH'(w_imm_raw);
        if (w_opcode == WRITE_OPCODE)
            w_imm = DATA_WIDTH'(w_wr_imm_raw);
        else
            w_imm = w_imm_norm;
    end

    assign w_pkt   = {w_opcode, w_rd, w_mode, w_ra, w_rb, w_imm, w_illegal};
    assign w_head  = r_mem[r_rd_ptr];

    assign O_ready = !I_reset && I_enable && !I_flush && (r_count < c_full_count);
    assign O_valid = (r_count != '0);
    assign w_push  = I_valid && O_ready;
    assign w_pop   = O_valid && I_ready && I_enable;

    assign {O_opcode, O_rD_select, O_mode, O_rA_select, O_rB_select, O_immediate, O_illegal} = w_head;
    assign O_decoded_count = r_decoded_count;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_decoded_count <= '0;
        end else if (I_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_pkt;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_decoded_count <= r_decoded_count + COUNT_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_pipe
// Brief    : Directed self-checking bench for decoder_pipe (default and
//            sign-extending / illegal-mask configurations side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_pipe;

    logic        clk;
    logic        I_reset;
    logic        I_enable;
    logic        I_flush;
    logic [15:0] I_instruction;
    logic        I_valid;
    logic        I_ready;

    logic        d_ready, d_mode, d_illegal, d_valid;
    logic [3:0]  d_opcode;
    logic [2:0]  d_rd, d_ra, d_rb;
    logic [15:0] d_imm, d_count;

    logic        s_ready, s_mode, s_illegal, s_valid;
    logic [3:0]  s_opcode;
    logic [2:0]  s_rd, s_ra, s_rb;
    logic [15:0] s_imm, s_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    decoder_pipe u_dut (
        .I_clk(clk), .I_reset(I_reset), .I_enable(I_enable), .I_flush(I_flush),
        .I_instruction(I_instruction), .I_valid(I_valid), .O_ready(d_ready),
        .O_opcode(d_opcode), .O_rD_select(d_rd), .O_rA_select(d_ra), .O_rB_select(d_rb),
        .O_mode(d_mode), .O_immediate(d_imm), .O_illegal(d_illegal), .O_valid(d_valid),
        .I_ready(I_ready), .O_decoded_count(d_count)
    );

    decoder_pipe #(.SIGN_EXT(1'b1), .ILLEGAL_MASK(16'h2000)) u_dut_s (
        .I_clk(clk), .I_reset(I_reset), .I_enable(I_enable), .I_flush(I_flush),
        .I_instruction(I_instruction), .I_valid(I_valid), .O_ready(s_ready),
        .O_opcode(s_opcode), .O_rD_select(s_rd), .O_rA_select(s_ra), .O_rB_select(s_rb),
        .O_mode(s_mode), .O_immediate(s_imm), .O_illegal(s_illegal), .O_valid(s_valid),
        .I_ready(I_ready), .O_decoded_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        I_reset = 1'b1; I_enable = 1'b1; I_flush = 1'b0;
        I_valid = 1'b1; I_instruction = 16'h1234; I_ready = 1'b1;
        tick;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready1: got %b expected 0", d_ready); end
        tick;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready2: got %b expected 0", d_ready); end
        n_checks++; if (d_valid !== 1'b0 || s_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", d_valid, s_valid); end
        n_checks++; if ({d_opcode, d_rd, d_mode, d_ra, d_rb, d_imm, d_illegal} !== '0) begin n_errors++; $display("FAIL reset_fields: got op=%h imm=%h expected all zero", d_opcode, d_imm); end
        n_checks++; if (d_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", d_count); end
        I_reset = 1'b0; I_valid = 1'b0; I_ready = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        I_instruction = 16'h1234; I_valid = 1'b1;
        #1;
        n_checks++; if (d_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready: got %b expected 1", d_ready); end
        tick;
        I_valid = 1'b0; exp_count++;
        n_checks++; if (d_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b expected 1", d_valid); end
        n_checks++; if ({d_opcode, d_rd, d_mode, d_ra, d_rb} !== {4'd1, 3'd1, 1'b0, 3'd1, 3'd5})
            begin n_errors++; $display("FAIL basic_fields: got op=%0d rd=%0d m=%b ra=%0d rb=%0d expected 1 1 0 1 5", d_opcode, d_rd, d_mode, d_ra, d_rb); end
        n_checks++; if (d_imm !== 16'h0034 || d_illegal !== 1'b0) begin n_errors++; $display("FAIL basic_imm: got %h ill=%b expected 0034 ill=0", d_imm, d_illegal); end
        n_checks++; if (d_count !== 16'(exp_count)) begin n_errors++; $display("FAIL basic_count: got %0d expected %0d", d_count, exp_count); end
        I_ready = 1'b1;
        tick;
        n_checks++; if (d_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b expected 0", d_valid); end
        I_ready = 1'b0;
    endtask

    task automatic test_write;
        I_instruction = 16'hF7A5; I_valid = 1'b1; I_ready = 1'b1;
        tick;
        I_valid = 1'b0; exp_count++;
        n_checks++; if (d_opcode !== 4'd15 || d_mode !== 1'b1) begin n_errors++; $display("FAIL write_op: got op=%0d m=%b expected 15 1", d_opcode, d_mode); end
        n_checks++; if (d_imm !== 16'h0074) begin n_errors++; $display("FAIL write_imm: got %h expected 0074", d_imm); end
        n_checks++; if (s_imm !== 16'h0074) begin n_errors++; $display("FAIL write_imm_sext: got %h expected 0074", s_imm); end
        tick;
        n_checks++; if (d_valid !== 1'b0) begin n_errors++; $display("FAIL write_drain: got %b expected 0", d_valid); end
        I_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        I_ready = 1'b1; I_valid = 1'b1; I_instruction = 16'h10F0;
        tick;
        I_instruction = 16'hD000;
        n_checks++; if (s_imm !== 16'hFFF0 || s_illegal !== 1'b0) begin n_errors++; $display("FAIL sext_imm: got %h ill=%b expected fff0 ill=0", s_imm, s_illegal); end
        n_checks++; if (d_imm !== 16'h00F0) begin n_errors++; $display("FAIL zext_imm: got %h expected 00f0", d_imm); end
        tick;
        I_valid = 1'b0; exp_count += 2;
        n_checks++; if (s_valid !== 1'b1 || s_opcode !== 4'd13 || s_illegal !== 1'b1)
            begin n_errors++; $display("FAIL illegal_flag: got v=%b op=%0d ill=%b expected 1 13 1", s_valid, s_opcode, s_illegal); end
        n_checks++; if (d_illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_nomask: got %b expected 0", d_illegal); end
        tick;
        n_checks++; if (s_valid !== 1'b0 || s_count !== 16'(exp_count)) begin n_errors++; $display("FAIL b2b_drain: got v=%b cnt=%0d expected 0 %0d", s_valid, s_count, exp_count); end
        I_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        I_ready = 1'b0; I_valid = 1'b1; I_instruction = 16'h1111;
        tick;
        I_instruction = 16'h2222;
        #1;
        n_checks++; if (d_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_1: got %b expected 1", d_ready); end
        tick;
        I_instruction = 16'h3333;
        #1;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready: got %b expected 0", d_ready); end
        tick;
        n_checks++; if (d_opcode !== 4'd1 || d_count !== 16'(exp_count + 2)) begin n_errors++; $display("FAIL bp_full_head: got op=%0d cnt=%0d expected 1 %0d", d_opcode, d_count, exp_count + 2); end
        I_ready = 1'b1;
        #1;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_pop_ready: got %b expected 0", d_ready); end
        tick;
        n_checks++; if (d_valid !== 1'b1 || d_opcode !== 4'd2 || d_ready !== 1'b1) begin n_errors++; $display("FAIL bp_pop1: got v=%b op=%0d rdy=%b expected 1 2 1", d_valid, d_opcode, d_ready); end
        tick;
        I_valid = 1'b0; exp_count += 3;
        n_checks++; if (d_opcode !== 4'd3 || d_count !== 16'(exp_count)) begin n_errors++; $display("FAIL bp_pop2: got op=%0d cnt=%0d expected 3 %0d", d_opcode, d_count, exp_count); end
        tick;
        n_checks++; if (d_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b expected 0", d_valid); end
        I_ready = 1'b0;
    endtask

    task automatic test_flush;
        I_ready = 1'b0; I_valid = 1'b1; I_instruction = 16'h4444;
        tick;
        I_instruction = 16'h5555;
        tick;
        exp_count += 2;
        I_flush = 1'b1; I_instruction = 16'h6666;
        #1;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", d_ready); end
        tick;
        I_flush = 1'b0; I_valid = 1'b0;
        n_checks++; if (d_valid !== 1'b0 || d_count !== 16'(exp_count)) begin n_errors++; $display("FAIL flush_state: got v=%b cnt=%0d expected 0 %0d", d_valid, d_count, exp_count); end
        I_valid = 1'b1; I_instruction = 16'h7777;
        tick;
        I_valid = 1'b0; exp_count++;
        n_checks++; if (d_valid !== 1'b1 || d_opcode !== 4'd7) begin n_errors++; $display("FAIL flush_refill: got v=%b op=%0d expected 1 7", d_valid, d_opcode); end
    endtask

    task automatic test_enable;
        I_enable = 1'b0; I_valid = 1'b1; I_instruction = 16'h8888; I_ready = 1'b1;
        #1;
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL enable_ready: got %b expected 0", d_ready); end
        tick;
        tick;
        n_checks++; if (d_valid !== 1'b1 || d_opcode !== 4'd7 || d_count !== 16'(exp_count))
            begin n_errors++; $display("FAIL enable_hold: got v=%b op=%0d cnt=%0d expected 1 7 %0d", d_valid, d_opcode, d_count, exp_count); end
        I_enable = 1'b1; I_valid = 1'b0;
        tick;
        n_checks++; if (d_valid !== 1'b0) begin n_errors++; $display("FAIL enable_resume: got %b expected 0", d_valid); end
        I_ready = 1'b0;
    endtask

    initial begin
        I_reset = 1'b1; I_enable = 1'b1; I_flush = 1'b0;
        I_valid = 1'b0; I_ready = 1'b0; I_instruction = '0;
        test_reset;
        test_basic;
        test_write;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_enable;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
